sram_access_arbiter: RTL

Parametrised N-master arbiter for the single-port SRAM_Controller. It generalises the fixed UART/VGA/Milestone mux at the top level. Masters request the bus, receive a registered grant, and drive address, write data and write enable through it. The block tags returning read data to the master that issued the read. It supports fixed-priority or round-robin arbitration, an optional ownership timeout, and a one-cycle turnaround on every ownership change.

---
 rtl/sram_access_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/sram_access_arbiter.sv
// N-master arbiter in front of the single-port SRAM controller: registered one-hot grant,
// burst lock, optional ownership timeout, one-cycle turnaround and read-data tagging.
module sram_access_arbiter #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned ADDR_WIDTH     = 18,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ARB_MODE       = 0,
  parameter int unsigned DEFAULT_MASTER = 0,
  parameter int unsigned READ_LATENCY   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                              Clock,
  input  logic                              Reset,
  input  logic [NUM_MASTERS-1:0]            Req,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] M_address,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] M_write_data,
  input  logic [NUM_MASTERS-1:0]            M_we_n,
  output logic [NUM_MASTERS-1:0]            Grant,
  output logic [2:0]                        Grant_index,
  output logic [NUM_MASTERS-1:0]            Read_valid,
  output logic [DATA_WIDTH-1:0]             Read_data,
  output logic                              Timeout_pulse,
  output logic [ADDR_WIDTH-1:0]             SRAM_address,
  output logic [DATA_WIDTH-1:0]             SRAM_write_data,
  output logic                              SRAM_we_n,
  input  logic [DATA_WIDTH-1:0]             SRAM_read_data
);

  localparam int unsigned CntMax = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int unsigned CntW   = (CntMax > 0) ? $clog2(CntMax + 1) : 1;

  typedef enum logic [1:0] {StIdle, StOwn, StTurn} state_e;

  state_e                  state_q, state_d;
  logic [NUM_MASTERS-1:0]  grant_q, grant_d;
  logic [2:0]              idx_q, idx_d, ptr_q, ptr_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    pulse_q, pulse_d;

  logic [2:0]              eff_ptr, win_idx, ptr_next;
  logic                    win_found;
  logic [NUM_MASTERS-1:0]  req_rot;
  int unsigned             j;
  logic                    owner_req, rival_req, timeout_hit;

  logic [READ_LATENCY-1:0]       tag_vld_q;
  logic [READ_LATENCY-1:0][2:0]  tag_idx_q;
  logic                          push_vld;

  // Rotate requests so the search always starts at bit 0; fixed priority uses pointer 0.
  always_comb begin
    eff_ptr   = (ARB_MODE == 1) ? ptr_q : 3'd0;
    req_rot   = NUM_MASTERS'({Req, Req} >> eff_ptr);
    win_found = 1'b0;
    win_idx   = 3'd0;
    j         = 0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      if (!win_found && req_rot[k]) begin
        win_found = 1'b1;
        j = 32'(eff_ptr) + k;
        if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
        win_idx = 3'(j);
      end
    end
    ptr_next = (win_idx == 3'(NUM_MASTERS - 1)) ? 3'd0 : win_idx + 3'd1;
  end

  assign owner_req   = |(Req & grant_q);
  assign rival_req   = |(Req & ~grant_q);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CntW'(CntMax)) && rival_req;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    unique case (state_q)
      StIdle, StTurn: begin
        grant_d = '0;
        if (win_found) begin
          grant_d = NUM_MASTERS'(1) << win_idx;
          idx_d   = win_idx;
          ptr_d   = ptr_next;
          cnt_d   = '0;
          state_d = StOwn;
        end else begin
          state_d = StIdle;
        end
      end
      StOwn: begin
        // A timeout revoke wins even if the owner is still requesting.
        if (timeout_hit || !owner_req) begin
          grant_d = '0;
          pulse_d = timeout_hit;
          state_d = StTurn;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q != CntW'(CntMax)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      idx_q   <= 3'd0;
      ptr_q   <= 3'd0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  // Read tags ride a shift register matching the SRAM read latency.
  assign push_vld = |(grant_q & M_we_n);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      tag_vld_q <= '0;
      tag_idx_q <= '0;
    end else begin
      tag_vld_q[0] <= push_vld;
      tag_idx_q[0] <= idx_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end
    end
  end

  always_comb begin
    Read_valid = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      Read_valid[i] = tag_vld_q[READ_LATENCY-1] && (tag_idx_q[READ_LATENCY-1] == 3'(i));
    end
  end

  always_comb begin
    SRAM_address    = M_address[DEFAULT_MASTER*ADDR_WIDTH +: ADDR_WIDTH];
    SRAM_write_data = '0;
    SRAM_we_n       = 1'b1;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        SRAM_address    = M_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        SRAM_write_data = M_write_data[i*DATA_WIDTH +: DATA_WIDTH];
        SRAM_we_n       = M_we_n[i];
      end
    end
  end

  assign Grant         = grant_q;
  assign Grant_index   = idx_q;
  assign Timeout_pulse = pulse_q;
  assign Read_data     = SRAM_read_data;

endmodule
